// File: rtl/mem_stage_ls_if.sv
// Bundle of the EX/MEM input, data-memory and WB-bound signals of mem_stage_ls.
// master: the stage itself; slave: the upstream/memory/WB environment.
interface mem_stage_ls_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic                in_valid;
  logic                in_ready;
  logic                mem_rd;
  logic                mem_wr;
  logic [2:0]          funct3;
  logic [2:0]          ctrl_wb_in;
  logic [REG_AW-1:0]   rd_mem;
  logic [XLEN-1:0]     pc4_mem;
  logic [XLEN-1:0]     alu_result;
  logic [XLEN-1:0]     write_data1;
  logic                dmem_req;
  logic                dmem_we;
  logic [XLEN-1:0]     dmem_addr;
  logic [XLEN-1:0]     dmem_wdata;
  logic [XLEN/8-1:0]   dmem_be;
  logic [XLEN-1:0]     dmem_rdata;
  logic                dmem_ack;
  logic                wb_valid;
  logic [2:0]          ctrl_wb;
  logic [REG_AW-1:0]   rd_wb;
  logic [XLEN-1:0]     pc4_wb;
  logic [XLEN-1:0]     alu_data;
  logic [XLEN-1:0]     mem_data;
  logic                misalign;
  logic                bus_err;

  modport master (
    input  in_valid, mem_rd, mem_wr, funct3, ctrl_wb_in, rd_mem, pc4_mem,
           alu_result, write_data1, dmem_rdata, dmem_ack,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, ctrl_wb, rd_wb, pc4_wb, alu_data, mem_data, misalign, bus_err
  );

  modport slave (
    output in_valid, mem_rd, mem_wr, funct3, ctrl_wb_in, rd_mem, pc4_mem,
           alu_result, write_data1, dmem_rdata, dmem_ack,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, ctrl_wb, rd_wb, pc4_wb, alu_data, mem_data, misalign, bus_err
  );
endinterface

// File: rtl/mem_stage_ls.sv
// MEM pipeline stage: byte-lane loads/stores with extension and misalignment
// detection, req/ack data-memory handshake with timeout, registered WB fields.
module mem_stage_ls #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_stage_ls_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_dmem_req, r_dmem_we, r_wb_valid, r_misalign, r_bus_err;
  logic [XLEN-1:0]   r_dmem_addr, r_dmem_wdata, r_pc4_wb, r_alu_data, r_mem_data;
  logic [NB-1:0]     r_dmem_be;
  logic [2:0]        r_ctrl_wb;
  logic [REG_AW-1:0] r_rd_wb;
  logic [2:0]        r_p_ctrl;
  logic [REG_AW-1:0] r_p_rd;
  logic [XLEN-1:0]   r_p_pc4, r_p_alu;
  logic [OW-1:0]     r_p_off;
  logic [1:0]        r_p_size;
  logic              r_p_uns;

  logic              w_accept, w_mem_op, w_legal, w_aligned, w_sign;
  logic [1:0]        w_size;
  logic [OW-1:0]     w_off;
  logic [2:0]        w_off3, w_lowmask;
  logic [NB-1:0]     w_size_be, w_be;
  logic [XLEN-1:0]   w_lane_mask, w_wdata, w_addr, w_shift, w_ext;
  int                w_nbits;

  assign w_accept = bus.in_valid & (r_state == S_IDLE);
  assign w_mem_op = bus.mem_rd | bus.mem_wr;
  assign w_size   = bus.funct3[1:0];
  assign w_off    = bus.alu_result[OW-1:0];
  assign w_off3   = 3'(w_off);
  assign w_addr   = {bus.alu_result[XLEN-1:OW], {OW{1'b0}}};
  assign w_be     = w_size_be << w_off;
  assign w_wdata  = (bus.write_data1 & w_lane_mask) << {w_off, 3'b000};
  assign w_shift  = bus.dmem_rdata >> {r_p_off, 3'b000};

  // Access legality: size/sign combination and direction.
  always_comb begin
    w_legal = 1'b1;
    if (bus.mem_rd & bus.mem_wr) begin
      w_legal = 1'b0;
    end else if (bus.funct3 == 3'b111) begin
      w_legal = 1'b0;
    end else if (bus.mem_wr & bus.funct3[2]) begin
      w_legal = 1'b0;
    end else if (((w_size == 2'b11) || (bus.funct3 == 3'b110)) && (XLEN != 64)) begin
      w_legal = 1'b0;
    end else begin
      w_legal = 1'b1;
    end
  end

  // Size decode: alignment mask, byte-enable pattern and data-lane mask.
  always_comb begin
    w_lowmask = 3'b000;
    w_size_be = '0;
    case (w_size)
      2'b00:   begin w_lowmask = 3'b000; w_size_be = NB'(8'h01); end
      2'b01:   begin w_lowmask = 3'b001; w_size_be = NB'(8'h03); end
      2'b10:   begin w_lowmask = 3'b011; w_size_be = NB'(8'h0F); end
      default: begin w_lowmask = 3'b111; w_size_be = NB'(8'hFF); end
    endcase
    w_aligned = ((w_off3 & w_lowmask) == 3'b000);
    w_lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      w_lane_mask[8*b +: 8] = {8{w_size_be[b]}};
    end
  end

  // Load data: lane-shifted read data truncated to size, then extended.
  always_comb begin
    w_nbits = int'(32'd8 << r_p_size);
    case (r_p_size)
      2'b00:   w_sign = ~r_p_uns & w_shift[7];
      2'b01:   w_sign = ~r_p_uns & w_shift[15];
      2'b10:   w_sign = ~r_p_uns & w_shift[31];
      default: w_sign = ~r_p_uns & w_shift[XLEN-1];
    endcase
    w_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_ext[i] = (i < w_nbits) ? w_shift[i] : w_sign;
    end
  end

  // Stage FSM: accept, issue/hold request, complete on ack or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= '0;
      r_wb_valid   <= 1'b0;
      r_ctrl_wb    <= 3'b000;
      r_rd_wb      <= '0;
      r_pc4_wb     <= '0;
      r_alu_data   <= '0;
      r_mem_data   <= '0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
      r_p_ctrl     <= 3'b000;
      r_p_rd       <= '0;
      r_p_pc4      <= '0;
      r_p_alu      <= '0;
      r_p_off      <= '0;
      r_p_size     <= 2'b00;
      r_p_uns      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p_ctrl <= bus.ctrl_wb_in;
            r_p_rd   <= bus.rd_mem;
            r_p_pc4  <= bus.pc4_mem;
            r_p_alu  <= bus.alu_result;
            r_p_off  <= w_off;
            r_p_size <= w_size;
            r_p_uns  <= bus.funct3[2];
            if (!w_mem_op || !(w_legal && w_aligned)) begin
              // Bad accesses retire immediately with writeback suppressed.
              r_wb_valid <= 1'b1;
              r_misalign <= w_mem_op;
              r_ctrl_wb  <= w_mem_op ? 3'b000 : bus.ctrl_wb_in;
              r_rd_wb    <= bus.rd_mem;
              r_pc4_wb   <= bus.pc4_mem;
              r_alu_data <= bus.alu_result;
              r_mem_data <= '0;
            end else begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= bus.mem_wr;
              r_dmem_addr  <= w_addr;
              r_dmem_be    <= bus.mem_wr ? w_be : '0;
              r_dmem_wdata <= bus.mem_wr ? w_wdata : '0;
              r_cnt        <= '0;
              r_state      <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (bus.dmem_ack || (r_cnt == CW'(MEM_TIMEOUT - 1))) begin
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b1;
            r_bus_err  <= ~bus.dmem_ack;
            r_ctrl_wb  <= bus.dmem_ack ? r_p_ctrl : 3'b000;
            r_rd_wb    <= r_p_rd;
            r_pc4_wb   <= r_p_pc4;
            r_alu_data <= r_p_alu;
            r_mem_data <= bus.dmem_ack ? w_ext : '0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.dmem_be    = r_dmem_be;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.ctrl_wb    = r_ctrl_wb;
  assign bus.rd_wb      = r_rd_wb;
  assign bus.pc4_wb     = r_pc4_wb;
  assign bus.alu_data   = r_alu_data;
  assign bus.mem_data   = r_mem_data;
  assign bus.misalign   = r_misalign;
  assign bus.bus_err    = r_bus_err;
endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: directed table and random transactions on a 32-bit
// instance against a reference model, plus hand sequences on a 64-bit instance.
module tb_mem_stage_ls;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_stage_ls_if #(.XLEN(32), .REG_AW(5)) b32 ();
  mem_stage_ls_if #(.XLEN(64), .REG_AW(5)) b64 ();

  mem_stage_ls #(.XLEN(32), .REG_AW(5), .MEM_TIMEOUT(TMO)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32));
  mem_stage_ls #(.XLEN(64), .REG_AW(5), .MEM_TIMEOUT(TMO)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64));

  typedef struct {
    logic        is_ld, is_st;
    logic [2:0]  f3, ctrl;
    logic [4:0]  rdx;
    logic [31:0] pc4, alu, wd, rdata;
    int          k;       // ACCESS cycles without ack before the ack cycle
    logic        err, berr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdat, mdat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, st, input logic [2:0] f3, ctrl,
                              input logic [4:0] rdx, input logic [31:0] pc4, alu, wd, rdata,
                              input int k, input logic err, berr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdat, mdat);
    vec_t v;
    v.is_ld = ld; v.is_st = st; v.f3 = f3; v.ctrl = ctrl; v.rdx = rdx;
    v.pc4 = pc4; v.alu = alu; v.wd = wd; v.rdata = rdata; v.k = k;
    v.err = err; v.berr = berr; v.addr = addr; v.be = be; v.wdat = wdat; v.mdat = mdat;
    return v;
  endfunction

  // Reference model for XLEN=32 built from the access-size rules.
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    int          sz, off;
    bit          sgn, legal;
    logic [63:0] m, val;
    e = v;
    sgn = 1'b0;
    case (v.f3)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: begin sz = 4; sgn = 1'b1; end
      3'd3: sz = 8;
      3'd4: sz = 1;
      3'd5: sz = 2;
      3'd6: sz = 4;
      default: sz = 0;
    endcase
    off = int'(v.alu % 32'd4);
    legal = !(v.is_ld && v.is_st) && (sz != 0) && (sz != 8) && (v.f3 != 3'd6)
            && !(v.is_st && v.f3 >= 3'd4);
    if (legal) legal = ((v.alu % sz) == 0);
    e.err  = (v.is_ld || v.is_st) && !legal;
    e.berr = (v.is_ld || v.is_st) && legal && (v.k + 1 > TMO);
    e.addr = v.alu - off;
    if (sz == 0) sz = 1;
    m      = (64'd1 << (8 * sz)) - 64'd1;
    e.be   = v.is_st ? 4'(((1 << sz) - 1) << off) : 4'd0;
    e.wdat = v.is_st ? 32'((({32'd0, v.wd}) & m) << (8 * off)) : 32'd0;
    val    = ({32'd0, v.rdata} >> (8 * off)) & m;
    if (sgn && ((val >> (8 * sz - 1)) & 64'd1) == 64'd1) val = val | ~m;
    e.mdat = val[31:0];
    return e;
  endfunction

  task automatic run_txn(input string nm, input vec_t v);
    bit   hold_bad, early_wb;
    logic mem;
    mem = v.is_ld | v.is_st;
    @(negedge clk);
    chk({nm, "_ready_pre"}, b32.in_ready, 1'b1);
    b32.in_valid = 1'b1; b32.mem_rd = v.is_ld; b32.mem_wr = v.is_st;
    b32.funct3 = v.f3; b32.ctrl_wb_in = v.ctrl; b32.rd_mem = v.rdx;
    b32.pc4_mem = v.pc4; b32.alu_result = v.alu; b32.write_data1 = v.wd;
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b32.mem_rd = 1'b0; b32.mem_wr = 1'b0;
    if (mem && !v.err) begin
      hold_bad = 1'b0; early_wb = 1'b0;
      for (int c = 1; c <= TMO; c++) begin
        @(negedge clk);
        if (b32.dmem_req !== 1'b1 || b32.in_ready !== 1'b0 || b32.dmem_we !== v.is_st ||
            b32.dmem_addr !== v.addr || b32.dmem_be !== v.be || b32.dmem_wdata !== v.wdat)
          hold_bad = 1'b1;
        if (b32.wb_valid !== 1'b0) early_wb = 1'b1;
        b32.dmem_ack = (c == v.k + 1);
        b32.dmem_rdata = v.rdata;
        @(posedge clk); #1;
        b32.dmem_ack = 1'b0;
        if (c == v.k + 1) break;
      end
      chk({nm, "_req_hold"}, hold_bad, 1'b0);
      chk({nm, "_wb_early"}, early_wb, 1'b0);
    end
    @(negedge clk);
    chk({nm, "_wb_valid"}, b32.wb_valid, 1'b1);
    chk({nm, "_misalign"}, b32.misalign, v.err);
    chk({nm, "_bus_err"}, b32.bus_err, v.berr);
    chk({nm, "_ctrl_wb"}, b32.ctrl_wb, (v.err || v.berr) ? 3'b000 : v.ctrl);
    chk({nm, "_rd_wb"}, b32.rd_wb, v.rdx);
    chk({nm, "_pc4_wb"}, b32.pc4_wb, v.pc4);
    chk({nm, "_alu_data"}, b32.alu_data, v.alu);
    chk({nm, "_req_done"}, b32.dmem_req, 1'b0);
    chk({nm, "_ready_post"}, b32.in_ready, 1'b1);
    if (v.is_ld && !v.is_st && !v.err && !v.berr) chk({nm, "_mem_data"}, b32.mem_data, v.mdat);
    @(negedge clk);
    chk({nm, "_pulse_end"}, {b32.wb_valid, b32.misalign, b32.bus_err}, 3'b000);
  endtask

  task automatic run64(input string nm, input logic ld, st, input logic [2:0] f3,
                       input logic [63:0] a, wd, rdata, exp_addr, input logic [7:0] exp_be,
                       input logic [63:0] exp_wd, exp_md);
    @(negedge clk);
    b64.in_valid = 1'b1; b64.mem_rd = ld; b64.mem_wr = st; b64.funct3 = f3;
    b64.ctrl_wb_in = 3'b001; b64.rd_mem = 5'd7; b64.pc4_mem = 64'h100;
    b64.alu_result = a; b64.write_data1 = wd;
    @(posedge clk); #1;
    b64.in_valid = 1'b0; b64.mem_rd = 1'b0; b64.mem_wr = 1'b0;
    @(negedge clk);
    chk({nm, "_req"}, b64.dmem_req, 1'b1);
    chk({nm, "_addr"}, b64.dmem_addr, exp_addr);
    chk({nm, "_be"}, b64.dmem_be, exp_be);
    chk({nm, "_wdata"}, b64.dmem_wdata, exp_wd);
    chk({nm, "_busy"}, b64.in_ready, 1'b0);
    b64.dmem_ack = 1'b1; b64.dmem_rdata = rdata;
    @(posedge clk); #1;
    b64.dmem_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_wb_valid"}, b64.wb_valid, 1'b1);
    chk({nm, "_ctrl_wb"}, b64.ctrl_wb, 3'b001);
    chk({nm, "_ready_post"}, b64.in_ready, 1'b1);
    if (ld) chk({nm, "_mem_data"}, b64.mem_data, exp_md);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    vec_t v;
    int   kind;

    reset_n = 1'b0;
    b32.in_valid = 1'b0; b32.mem_rd = 1'b0; b32.mem_wr = 1'b0; b32.funct3 = 3'd0;
    b32.ctrl_wb_in = 3'd0; b32.rd_mem = 5'd0; b32.pc4_mem = '0; b32.alu_result = '0;
    b32.write_data1 = '0; b32.dmem_rdata = '0; b32.dmem_ack = 1'b0;
    b64.in_valid = 1'b0; b64.mem_rd = 1'b0; b64.mem_wr = 1'b0; b64.funct3 = 3'd0;
    b64.ctrl_wb_in = 3'd0; b64.rd_mem = 5'd0; b64.pc4_mem = '0; b64.alu_result = '0;
    b64.write_data1 = '0; b64.dmem_rdata = '0; b64.dmem_ack = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", b32.in_ready, 1'b1);
    chk("rst_req_we", {b32.dmem_req, b32.dmem_we}, 2'b00);
    chk("rst_be", b32.dmem_be, 4'h0);
    chk("rst_pulses", {b32.wb_valid, b32.misalign, b32.bus_err}, 3'b000);
    chk("rst_wb", {b32.ctrl_wb, b32.rd_wb, b32.alu_data, b32.mem_data}, 64'd0);
    chk("rst_addr64", b64.dmem_addr, 64'd0);
    reset_n = 1'b1;

    //         ld    st    f3      ctrl    rd  pc4      alu           wd            rdata         k   err   berr  addr          be       wdat          mdat
    tab.push_back(mk(1'b0, 1'b0, 3'b000, 3'b101, 5,  32'h44, 32'h1234,     32'h0,        32'h0,        0,  1'b0, 1'b0, 32'h0,        4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b0, 1'b1, 3'b000, 3'b010, 6,  32'h48, 32'h103,      32'hA5,       32'h0,        3,  1'b0, 1'b0, 32'h100,      4'b1000, 32'hA5000000, 32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b000, 3'b011, 10, 32'h4C, 32'h102,      32'h0,        32'h00800000, 1,  1'b0, 1'b0, 32'h100,      4'b0000, 32'h0,        32'hFFFFFF80));
    tab.push_back(mk(1'b1, 1'b0, 3'b100, 3'b011, 10, 32'h50, 32'h102,      32'h0,        32'h00800000, 1,  1'b0, 1'b0, 32'h100,      4'b0000, 32'h0,        32'h00000080));
    tab.push_back(mk(1'b1, 1'b0, 3'b010, 3'b011, 11, 32'h54, 32'h202,      32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h200,      4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b001, 3'b011, 12, 32'h58, 32'h201,      32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h200,      4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b010, 3'b011, 13, 32'h5C, 32'h300,      32'h0,        32'h12345678, 20, 1'b0, 1'b1, 32'h300,      4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b010, 3'b011, 14, 32'h60, 32'h300,      32'h0,        32'hDEADBEEF, 14, 1'b0, 1'b0, 32'h300,      4'b0000, 32'h0,        32'hDEADBEEF));
    tab.push_back(mk(1'b0, 1'b1, 3'b001, 3'b000, 0,  32'h64, 32'h102,      32'h1234BEEF, 32'h0,        0,  1'b0, 1'b0, 32'h100,      4'b1100, 32'hBEEF0000, 32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b001, 3'b011, 15, 32'h68, 32'h102,      32'h0,        32'h80010000, 0,  1'b0, 1'b0, 32'h100,      4'b0000, 32'h0,        32'hFFFF8001));
    tab.push_back(mk(1'b1, 1'b0, 3'b101, 3'b011, 16, 32'h6C, 32'h102,      32'h0,        32'h80010000, 0,  1'b0, 1'b0, 32'h100,      4'b0000, 32'h0,        32'h00008001));
    tab.push_back(mk(1'b1, 1'b1, 3'b010, 3'b011, 17, 32'h70, 32'h10,       32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h10,       4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b111, 3'b011, 18, 32'h74, 32'h20,       32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h20,       4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b1, 1'b0, 3'b110, 3'b011, 19, 32'h78, 32'h20,       32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h20,       4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b0, 1'b1, 3'b011, 3'b000, 0,  32'h7C, 32'h20,       32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h20,       4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b0, 1'b1, 3'b100, 3'b000, 0,  32'h80, 32'h21,       32'h0,        32'h0,        0,  1'b1, 1'b0, 32'h20,       4'b0000, 32'h0,        32'h0));
    tab.push_back(mk(1'b0, 1'b1, 3'b010, 3'b000, 0,  32'h84, 32'h204,      32'hCAFEF00D, 32'h0,        2,  1'b0, 1'b0, 32'h204,      4'b1111, 32'hCAFEF00D, 32'h0));
    tab.push_back(mk(1'b0, 1'b1, 3'b000, 3'b000, 0,  32'h88, 32'h400,      32'h12345677, 32'h0,        0,  1'b0, 1'b0, 32'h400,      4'b0001, 32'h00000077, 32'h0));

    for (int i = 0; i < tab.size(); i++) run_txn($sformatf("dir%0d", i), tab[i]);

    // Ack while idle must be ignored.
    @(negedge clk);
    b32.dmem_ack = 1'b1; b32.dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    b32.dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_wb", {b32.wb_valid, b32.bus_err, b32.dmem_req}, 3'b000);
    chk("idle_ack_ready", b32.in_ready, 1'b1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      v.is_ld = (kind >= 2 && kind <= 5) || kind == 9;
      v.is_st = (kind >= 6);
      v.f3 = 3'($urandom_range(0, 7));
      v.ctrl = 3'($urandom_range(1, 7));
      v.rdx = 5'($urandom_range(0, 31));
      v.pc4 = $urandom;
      v.alu = $urandom;
      v.wd = $urandom;
      v.rdata = $urandom;
      v.k = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 4);
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    run64("lwu64", 1'b1, 1'b0, 3'b110, 64'h4, 64'h0, 64'hFFFFFFFF_00000000,
          64'h0, 8'h00, 64'h0, 64'h00000000_FFFFFFFF);
    run64("lw64", 1'b1, 1'b0, 3'b010, 64'h4, 64'h0, 64'hFFFFFFFF_00000000,
          64'h0, 8'h00, 64'h0, 64'hFFFFFFFF_FFFFFFFF);
    run64("ld64", 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 64'h80000000_00000001,
          64'h10, 8'h00, 64'h0, 64'h80000000_00000001);
    run64("sw64", 1'b0, 1'b1, 3'b010, 64'hC, 64'h11223344_AABBCCDD, 64'h0,
          64'h8, 8'hF0, 64'hAABBCCDD_00000000, 64'h0);
    run64("sd64", 1'b0, 1'b1, 3'b011, 64'h18, 64'h01234567_89ABCDEF, 64'h0,
          64'h18, 8'hFF, 64'h01234567_89ABCDEF, 64'h0);

    // Reset in the middle of an access abandons it at once.
    @(negedge clk);
    b64.in_valid = 1'b1; b64.mem_rd = 1'b1; b64.funct3 = 3'b011; b64.alu_result = 64'h20;
    @(posedge clk); #1;
    b64.in_valid = 1'b0; b64.mem_rd = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_req_before", b64.dmem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", b64.dmem_req, 1'b0);
    chk("mid_rst_ready", b64.in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run64("ld64_after_rst", 1'b1, 1'b0, 3'b000, 64'h27, 64'h0, 64'h7F00000000000000,
          64'h20, 8'h00, 64'h0, 64'h000000000000007F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
